// File: rtl/encoder_gen.sv
// encoder_gen: quadrature A/B pulse generator that walks a commanded number of phase steps
// at a programmable rate. Define ENCODER_GEN_ABORT_EN to add the cmd_abort input.
module encoder_gen #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             cmd_dir,
   input  logic [DIV_W-1:0] cmd_period,
`ifdef ENCODER_GEN_ABORT_EN
   input  logic             cmd_abort,
`endif
   output logic             enc_a,
   output logic             enc_b,
   output logic             busy,
   output logic [CNT_W-1:0] steps_left,
   output logic             done
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   typedef struct packed {
      logic             dir;
      logic [DIV_W-1:0] period;
   } cmd_t;

   state_t           state, state_nxt;
   cmd_t             cmd_q;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] period_eff;
   logic             accept, zero_cmd, run_cmd;
   logic             abort_run, tick, step, last_step;

   assign period_eff = (cmd_period == '0) ? DIV_W'(1) : cmd_period;
   assign accept     = cmd_valid && cmd_ready;
   assign zero_cmd   = accept && (cmd_steps == '0);
   assign run_cmd    = accept && (cmd_steps != '0);

`ifdef ENCODER_GEN_ABORT_EN
   assign abort_run = cmd_abort && (state == S_RUN);
`else
   assign abort_run = 1'b0;
`endif

   // Abort suppresses the step even when it lands on the terminal count.
   assign tick      = (state == S_RUN) && (cnt == '0) && (steps_left != '0);
   assign step      = tick && !abort_run;
   assign last_step = step && (steps_left == CNT_W'(1));

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (run_cmd) state_nxt = S_RUN;
         S_RUN:   if (abort_run || last_step) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         S_IDLE:  cmd_ready = !reset;
         S_RUN:   busy      = 1'b1;
         default: ;
      endcase
   end

   // Phase is held in A/B directly; forward rotates {A,B} <= {~B,A}, reverse {B,~A}.
   always_ff @(posedge clk) begin
      if (reset) begin
         cmd_q      <= '0;
         cnt        <= '0;
         steps_left <= '0;
         enc_a      <= 1'b0;
         enc_b      <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= zero_cmd || last_step || abort_run;
         if (run_cmd) begin
            cmd_q.dir    <= cmd_dir;
            cmd_q.period <= period_eff;
            cnt          <= period_eff - DIV_W'(1);
            steps_left   <= cmd_steps;
         end else if (step) begin
            cnt        <= cmd_q.period - DIV_W'(1);
            steps_left <= steps_left - CNT_W'(1);
            if (cmd_q.dir) begin
               enc_a <= ~enc_b;
               enc_b <= enc_a;
            end else begin
               enc_a <= enc_b;
               enc_b <= ~enc_a;
            end
         end else if ((state == S_RUN) && !abort_run) begin
            cnt <= cnt - DIV_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_encoder_gen.sv
// tb_encoder_gen: randomized and directed commands checked every cycle against a
// closed-form timeline model (step k of a command lands at accept edge + k*P).
module tb_encoder_gen;
   localparam int DIV_W = 16;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps = '0;
   logic             cmd_dir = 1'b0;
   logic [DIV_W-1:0] cmd_period = '0;
   logic             cmd_abort = 1'b0;
   logic             enc_a, enc_b, busy, done;
   logic [CNT_W-1:0] steps_left;

   encoder_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_steps  (cmd_steps),
      .cmd_dir    (cmd_dir),
      .cmd_period (cmd_period),
`ifdef ENCODER_GEN_ABORT_EN
      .cmd_abort  (cmd_abort),
`endif
      .enc_a      (enc_a),
      .enc_b      (enc_b),
      .busy       (busy),
      .steps_left (steps_left),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int n;
      int p;
      bit dir;
   } cmd_s;

   cmd_s q[$];
   int   n_tot = 0, n_bad = 0;
   int   cyc = 0;
   int   abort_at = -1;

   // reference model state: one active command described by its accept edge and fields
   bit   have = 0, aborted = 0;
   int   m_t, m_n, m_p, m_dir, m_a;
   int   m_base = 0, m_sl_base = 0;
   int   e_busy = 0, e_ph = 0, e_sl = 0, e_done = 0;
   logic [1:0] gray_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int steps_done(input int c);
      int lim, k;
      lim = c;
      if (aborted && lim > m_a - 1) lim = m_a - 1;
      if (lim < m_t) return 0;
      k = (lim - m_t) / m_p;
      return (k > m_n) ? m_n : k;
   endfunction

   task automatic tick_cycle();
      int end_c, k, ph;
      @(posedge clk);
      cyc++;
      if (reset) begin
         have = 0; aborted = 0; m_base = 0; m_sl_base = 0;
      end else if (cmd_valid && e_busy == 0) begin
         m_base    = e_ph;
         m_sl_base = e_sl;
         m_n       = int'(cmd_steps);
         m_p       = (cmd_period == '0) ? 1 : int'(cmd_period);
         m_dir     = int'(cmd_dir);
         m_t       = cyc;
         have      = 1;
         aborted   = 0;
         void'(q.pop_front());
      end
`ifdef ENCODER_GEN_ABORT_EN
      else if (cmd_abort && e_busy != 0) begin
         aborted = 1;
         m_a     = cyc;
      end
`endif
      if (have) begin
         end_c  = aborted ? m_a : m_t + m_n * m_p;
         k      = steps_done(cyc);
         e_busy = (cyc < end_c) ? 1 : 0;
         e_done = (cyc == end_c) ? 1 : 0;
         e_sl   = (m_n == 0) ? m_sl_base : m_n - k;
         ph     = m_base + (m_dir != 0 ? k : -k);
         e_ph   = ((ph % 4) + 4) % 4;
      end else begin
         e_busy = 0; e_done = 0; e_sl = m_sl_base; e_ph = m_base;
      end
      #1;
      chk("enc_ab", {30'd0, enc_a, enc_b}, {30'd0, gray_tab[e_ph]});
      chk("busy", {31'd0, busy}, e_busy);
      chk("done", {31'd0, done}, e_done);
      chk("steps_left", {16'd0, steps_left}, e_sl);
      chk("cmd_ready", {31'd0, cmd_ready}, (!reset && e_busy == 0) ? 1 : 0);
      cmd_valid = (q.size() > 0);
      if (cmd_valid) begin
         cmd_steps  = CNT_W'(q[0].n);
         cmd_period = DIV_W'(q[0].p);
         cmd_dir    = q[0].dir;
      end else begin
         cmd_steps  = CNT_W'($urandom);
         cmd_period = DIV_W'($urandom);
         cmd_dir    = 1'($urandom);
      end
      cmd_abort = (abort_at == cyc + 1);
   endtask

   task automatic push(input int n, input int p, input bit dir);
      cmd_s c;
      c.n = n; c.p = p; c.dir = dir;
      q.push_back(c);
      cmd_valid  = 1'b1;
      cmd_steps  = CNT_W'(n);
      cmd_period = DIV_W'(p);
      cmd_dir    = dir;
   endtask

   task automatic drain();
      int guard = 0;
      while ((q.size() > 0 || e_busy != 0 || abort_at > cyc) && guard < 3000) begin
         tick_cycle();
         guard++;
      end
      if (guard >= 3000) chk("drain_timeout", 1, 0);
      repeat (2) tick_cycle();
   endtask

   task automatic wait_accept();
      int guard = 0;
      while (q.size() > 0 && guard < 200) begin
         tick_cycle();
         guard++;
      end
      if (guard >= 200) chk("accept_timeout", 1, 0);
   endtask

   initial begin
      repeat (3) tick_cycle();
      reset = 1'b0;
      tick_cycle();

      push(4, 3, 1'b1);  drain();
      push(2, 1, 1'b0);  drain();
      push(0, 5, 1'b1);  drain();
      push(3, 0, 1'b1);  drain();
      push(3, 2, 1'b1);  push(1, 2, 1'b1);  drain();

      // reset lands on accept edge + 5 of a long run
      push(10, 2, 1'b1);
      wait_accept();
      repeat (4) tick_cycle();
      reset = 1'b1;
      tick_cycle();
      reset = 1'b0;
      drain();

`ifdef ENCODER_GEN_ABORT_EN
      push(8, 2, 1'b1);
      wait_accept();
      abort_at = cyc + 7;
      drain();
      push(0, 1, 1'b0);  drain();
      abort_at = cyc + 2;
      repeat (4) tick_cycle();
`endif

      for (int i = 0; i < 40; i++) begin
         push($urandom_range(0, 12), $urandom_range(0, 4), 1'($urandom));
         if ($urandom_range(0, 2) == 0)
            push($urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom));
`ifdef ENCODER_GEN_ABORT_EN
         if ($urandom_range(0, 3) == 0) abort_at = cyc + $urandom_range(2, 20);
`endif
         drain();
         repeat ($urandom_range(0, 3)) tick_cycle();
      end

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
